// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory-access stage with a single-outstanding req/ack port,
//            byte-lane steering, load extension and fault detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic                 i_Write,
  input  logic [2:0]           i_Funct3,
  input  logic [WORD_SIZE-1:0] i_Addr,
  input  logic [WORD_SIZE-1:0] i_WData,
  output logic                 o_MemReq,
  output logic                 o_MemWe,
  output logic [WORD_SIZE-1:0] o_MemAddr,
  output logic [3:0]           o_MemBe,
  output logic [WORD_SIZE-1:0] o_MemWData,
  input  logic                 i_MemAck,
  input  logic [WORD_SIZE-1:0] i_MemRData,
  output logic                 o_Done,
  output logic [WORD_SIZE-1:0] o_RData,
  output logic [1:0]           o_ErrCode
);

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_off;
  logic [2:0]           r_funct3;
  logic                 r_write;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [3:0]           r_mem_be;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [1:0]           r_err;

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_misaligned;
  logic                 w_timeout;
  logic [3:0]           w_be;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [WORD_SIZE-1:0] w_lane;
  logic [WORD_SIZE-1:0] w_load;

  assign w_accept  = i_Valid && (r_state == S_IDLE);
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_CNT_W'(TIMEOUT - 1));

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
  always_comb begin
    w_illegal    = i_Write ? (i_Funct3 >= 3'b011)
                           : ((i_Funct3 == 3'b011) || (i_Funct3[2:1] == 2'b11));
    w_misaligned = ((i_Funct3[1:0] == 2'b01) && i_Addr[0]) ||
                   ((i_Funct3[1:0] == 2'b10) && (i_Addr[1:0] != 2'b00));
    case (i_Funct3[1:0])
      2'b00:   begin
        w_be    = 4'b0001 << i_Addr[1:0];
        w_wdata = {4{i_WData[7:0]}};
      end
      2'b01:   begin
        w_be    = i_Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_WData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_WData;
      end
    endcase
  end

  always_comb begin
    w_lane = i_MemRData >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{(WORD_SIZE-8){w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {{(WORD_SIZE-8){1'b0}}, w_lane[7:0]};
      3'b001:  w_load = {{(WORD_SIZE-16){w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load = {{(WORD_SIZE-16){1'b0}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_Ready  = 1'b0;
    o_MemReq = 1'b0;
    o_Done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) w_next = (w_illegal || w_misaligned) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        o_MemReq = 1'b1;
        if (i_MemAck || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        o_Done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers change only on entry to RESP, so they hold between completions
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_off       <= '0;
      r_funct3    <= '0;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 2'b00;
    end else begin
      if (w_accept) begin
        r_off    <= i_Addr[1:0];
        r_funct3 <= i_Funct3;
        r_write  <= i_Write;
        r_cnt    <= '0;
        if (w_illegal) begin
          r_err   <= 2'b11;
          r_rdata <= '0;
        end else if (w_misaligned) begin
          r_err   <= 2'b01;
          r_rdata <= '0;
        end else begin
          r_mem_we    <= i_Write;
          r_mem_addr  <= {i_Addr[WORD_SIZE-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
        end
      end else if (r_state == S_REQ) begin
        if (i_MemAck) begin
          r_rdata  <= r_write ? '0 : w_load;
          r_err    <= 2'b00;
          r_mem_we <= 1'b0;
        end else if (w_timeout) begin
          r_rdata  <= '0;
          r_err    <= 2'b10;
          r_mem_we <= 1'b0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign o_MemWe    = r_mem_we;
  assign o_MemAddr  = r_mem_addr;
  assign o_MemBe    = r_mem_be;
  assign o_MemWData = r_mem_wdata;
  assign o_RData    = r_rdata;
  assign o_ErrCode  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a random-latency memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_Valid = 1'b0;
  logic        i_Write = 1'b0;
  logic [2:0]  i_Funct3 = '0;
  logic [31:0] i_Addr = '0;
  logic [31:0] i_WData = '0;
  logic        i_MemAck = 1'b0;
  logic [31:0] i_MemRData = '0;
  logic        o_Ready, o_MemReq, o_MemWe, o_Done;
  logic [31:0] o_MemAddr, o_MemWData, o_RData;
  logic [3:0]  o_MemBe;
  logic [1:0]  o_ErrCode;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Write(i_Write), .i_Funct3(i_Funct3), .i_Addr(i_Addr), .i_WData(i_WData),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemBe(o_MemBe),
    .o_MemWData(o_MemWData), .i_MemAck(i_MemAck), .i_MemRData(i_MemRData),
    .o_Done(o_Done), .o_RData(o_RData), .o_ErrCode(o_ErrCode)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          req_len;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 0;
  logic [31:0] mem_word = '0;

  // Reference: derive the response from access size, offset and ack delay
  function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] mw, input int dly);
    exp_t        e;
    int          nb, off;
    logic        illegal;
    logic [63:0] mask, val;
    nb      = 1 << f3[1:0];
    off     = int'(addr[1:0]);
    illegal = w ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
    e.maddr = addr & ~32'h3;
    e.be    = 4'(((1 << nb) - 1) << off);
    e.we    = w;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    e.rdata = '0;
    if (illegal) begin
      e.err = 2'b11; e.lat = 1; e.req_len = 0;
    end else if ((off % nb) != 0) begin
      e.err = 2'b01; e.lat = 1; e.req_len = 0;
    end else if (dly >= TIMEOUT) begin
      e.err = 2'b10; e.lat = TIMEOUT + 1; e.req_len = TIMEOUT;
    end else begin
      e.err = 2'b00; e.lat = dly + 2; e.req_len = dly + 1;
      if (!w) begin
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val  = (64'(mw) >> (8 * off)) & mask;
        if (!f3[2] && val[8*nb-1]) val = val | ~mask;
        e.rdata = val[31:0];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory model: acks on the ack_delay-th request cycle, random noise otherwise
  int req_idx = 0;
  always @(negedge clk) begin
    if (o_MemReq) begin
      i_MemAck   = (req_idx == ack_delay);
      i_MemRData = i_MemAck ? mem_word : $urandom;
      req_idx++;
    end else begin
      i_MemAck   = ($urandom_range(3) == 0);
      i_MemRData = $urandom;
      req_idx    = 0;
    end
  end

  // Monitor: pops the scoreboard on every completion
  bit busy = 1'b0;
  bit prev_req = 1'b0;
  int lat = 0;
  int req_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst_n) begin
      chk("reset_ctrl", {58'd0, o_Ready, o_MemReq, o_MemWe, o_Done, o_ErrCode}, {58'd0, 6'b100000});
      chk("reset_bus", {o_MemAddr, o_RData}, 64'd0);
      chk("reset_bus2", {28'd0, o_MemBe, o_MemWData}, 64'd0);
      exp_q.delete();
      busy     = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (busy) lat++;
      if (o_MemReq) begin
        req_len++;
        if (!prev_req) begin
          if (!busy || exp_q.size() == 0) chk("spurious_memreq", {63'd0, o_MemReq}, 64'd0);
          else begin
            e = exp_q[0];
            chk("mem_addr", {32'd0, o_MemAddr}, {32'd0, e.maddr});
            chk("mem_be_we", {59'd0, o_MemBe, o_MemWe}, {59'd0, e.be, e.we});
            if (e.we) chk("mem_wdata", {32'd0, o_MemWData}, {32'd0, e.wdata});
          end
        end
      end
      if (o_Done) begin
        if (!busy || exp_q.size() == 0) chk("spurious_done", {63'd0, o_Done}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", {32'd0, o_RData}, {32'd0, e.rdata});
          chk("err_code", {62'd0, o_ErrCode}, {62'd0, e.err});
          chk("done_latency", 64'(lat), 64'(e.lat));
          chk("memreq_cycles", 64'(req_len), 64'(e.req_len));
        end
        busy = 1'b0;
      end else if (busy && lat > 300) begin
        e = exp_q.pop_front();
        chk("done_latency", 64'(lat), 64'(e.lat));
        busy = 1'b0;
      end
      if (o_Ready && i_Valid) begin
        busy    = 1'b1;
        lat     = 0;
        req_len = 0;
      end
      prev_req = o_MemReq;
    end
  end

  // Called at posedge+#1; holds junk on the inputs while the unit is busy
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] mw, input int dly);
    int k;
    k = 0;
    while (!o_Ready && k < 400) begin @(posedge clk); #1; k++; end
    mem_word  = mw;
    ack_delay = dly;
    exp_q.push_back(model(w, f3, addr, wd, mw, dly));
    i_Valid = 1'b1; i_Write = w; i_Funct3 = f3; i_Addr = addr; i_WData = wd;
    @(posedge clk); #1;
    i_Write = 1'($urandom); i_Funct3 = 3'($urandom); i_Addr = $urandom; i_WData = $urandom;
    k = 0;
    while (!o_Done && k < 400) begin @(posedge clk); #1; k++; end
    i_Valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, d;
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);   // LB
    issue(1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0001, 0);   // LHU
    issue(1'b0, 3'b001, 32'h202, 32'h0, 32'hBEEF_0001, 1);   // LH
    issue(1'b1, 3'b001, 32'h006, 32'h1234_ABCD, 32'h0, 2);   // SH
    issue(1'b0, 3'b010, 32'h001, 32'h0, 32'h0, 0);           // LW misaligned
    issue(1'b1, 3'b011, 32'h001, 32'h0, 32'h0, 0);           // illegal store
    issue(1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFE_F00D, NEVER);
    issue(1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);

    // Abort an access in its second request cycle
    mem_word  = 32'h0;
    ack_delay = NEVER;
    exp_q.push_back(model(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, NEVER));
    i_Valid = 1'b1; i_Write = 1'b0; i_Funct3 = 3'b010; i_Addr = 32'h40;
    @(posedge clk); #1;
    i_Valid = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 3'b010, 32'h010, 32'h5A5A_1234, 32'h0, 1);   // SW after reset

    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(1));
      f3 = 3'($urandom_range(7));
      a  = $urandom;
      r  = $urandom_range(9);
      d  = (r == 0) ? NEVER : (r == 1) ? $urandom_range(TIMEOUT, TIMEOUT - 2) : $urandom_range(4);
      issue(w, f3, a, $urandom, $urandom, d);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Takes the ALU result as the effective address, plus rs2 store data and the RV32I load/store funct3.
- Drives a single-outstanding request/acknowledge data-memory port, handles byte lanes and sign extension, and returns one completion per request to writeback.
- Detects misaligned accesses, illegal funct3 and memory-timeout faults.

Parameters:
- WORD_SIZE, 32, datapath width; only 32 is supported.
- TIMEOUT, 16, maximum cycles o_MemReq may be held without i_MemAck before an access fault is raised; 0 disables the timeout.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_Valid  input  1  request valid from execute.
- o_Ready  output  1  unit can accept a request; high only in IDLE.
- i_Write  input  1  1 = store, 0 = load.
- i_Funct3  input  3  RV32I load/store funct3.
- i_Addr  input  WORD_SIZE  effective address (ALU result).
- i_WData  input  WORD_SIZE  store data (rs2).
- o_MemReq  output  1  memory request, held until ack or timeout.
- o_MemWe  output  1  memory write enable.
- o_MemAddr  output  WORD_SIZE  word-aligned address, i.e. {addr[31:2],2'b00}.
- o_MemBe  output  4  byte enables.
- o_MemWData  output  WORD_SIZE  lane-replicated store data.
- i_MemAck  input  1  memory acknowledge; read data is valid in the same cycle.
- i_MemRData  input  WORD_SIZE  memory read data.
- o_Done  output  1  one-cycle completion pulse.
- o_RData  output  WORD_SIZE  extended load result; 0 for stores and errors.
- o_ErrCode  output  2  valid with o_Done: 00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.

Behaviour:
- Reset values: all outputs 0 except o_Ready=1; state IDLE; timeout counter 0.
- Reset is asynchronous: asserting i_rst_n low mid-access drops o_MemReq immediately. No o_Done is produced for an aborted access.

State machine: IDLE, REQ, RESP.
- Handshake: a request is accepted on a rising edge where i_Valid & o_Ready. Addr, data, funct3 and write are registered at that edge.
- Legality check at accept:
  - Illegal funct3: loads 011, 110, 111; stores >= 011.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
  - On an illegal or misaligned request: IDLE->RESP, no memory request, o_ErrCode=11 or 01. Illegal takes priority over misaligned.
- Legal request: IDLE->REQ. o_MemReq, o_MemWe, o_MemAddr, o_MemBe and o_MemWData are registered and stable from the next cycle until the request leaves REQ.
- Store lanes (o = addr[1:0]):
  - SB: Be = 0001<<o, WData = {4{wdata[7:0]}}.
  - SH: Be = 0011 if o=00, 1100 if o=10; WData = {2{wdata[15:0]}}.
  - SW: Be = 1111.
- Loads: o_MemWe=0 and o_MemBe is set the same way as for stores, for observability.
- REQ:
  - On i_MemAck: capture extended read data, go to RESP, drop o_MemReq on the next edge.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack (TIMEOUT>0): go to RESP with ErrCode=10 and drop the request.
  - Ack in the same cycle as timeout expiry: the ack wins.
- Load extraction: lane = i_MemRData >> (8*o).
  - LB: sign-extend lane[7:0]; LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]; LHU: zero-extend lane[15:0].
  - LW: full word.
- RESP: o_Done=1 for exactly one cycle with o_RData/o_ErrCode valid, then IDLE. o_RData/o_ErrCode hold their values until the next o_Done.
- Latency:
  - Legal access with ack on the first REQ cycle: accept edge N, o_MemReq high in cycle N+1, o_Done in cycle N+2.
  - Error-at-accept: o_Done in cycle N+1.
- o_Ready is low in REQ and RESP, so back-to-back accesses are spaced by at least one IDLE cycle. i_Valid while not ready is ignored; no queuing.
- i_MemAck outside REQ is ignored.
- The timeout counter is cleared on every entry to REQ.

Test Plan:
- LB at addr 0x103, mem word 0x80FF_1234 -> MemAddr 0x100, Be 1000, o_RData 0xFFFF_FF80, ErrCode 00, o_Done two cycles after accept.
- LHU at 0x202, mem 0xBEEF_0001 -> o_RData 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SH at 0x006 with wdata 0x1234_ABCD -> MemWe 1, Be 1100, MemWData 0xABCD_ABCD; ack after 3 cycles -> single o_Done, ErrCode 00, o_RData 0.
- LW at 0x001 -> no o_MemReq ever asserted, o_Done the next cycle with ErrCode 01. Store with funct3 011 at 0x001 -> ErrCode 11.
- LW at 0x40, TIMEOUT=16, ack never asserted:
  - o_MemReq high for exactly 16 cycles, then o_Done with ErrCode 10.
  - Repeat with ack in the 16th cycle -> ErrCode 00 and correct data.
- Reset in the 2nd REQ cycle -> o_MemReq low immediately, o_Ready 1, no o_Done. A following SW at 0x10 completes normally.
